// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage. Holds the ID/EX register, runs the ALU,
// issues the data SRAM request, forms the EX->MEM and forwarding buses and
// sequences a 32-step restoring divider for div/divu.
module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int STALL_WD     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [37:0]             ex_to_id_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    hilo_we,
  output logic [31:0]             hi_wdata,
  output logic [31:0]             lo_wdata,
  output logic                    stallreq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;

  logic [ID_TO_EX_WD-1:0] id_ex_q, id_ex_d;
  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d, dz_q, dz_d;

  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2;
  logic [3:0]  ram_wen;
  logic [4:0]  rf_waddr;
  logic        ram_en, rf_we, sel_rf_res;

  assign pc         = id_ex_q[158:127];
  assign inst       = id_ex_q[126:95];
  assign alu_op     = id_ex_q[94:83];
  assign sel_src1   = id_ex_q[82:80];
  assign sel_src2   = id_ex_q[79:76];
  assign ram_en     = id_ex_q[75];
  assign ram_wen    = id_ex_q[74:71];
  assign rf_we      = id_ex_q[70];
  assign rf_waddr   = id_ex_q[69:65];
  assign sel_rf_res = id_ex_q[64];
  assign rdata1     = id_ex_q[63:32];
  assign rdata2     = id_ex_q[31:0];

  logic is_div, is_signed_div;
  assign is_div        = (inst[31:26] == 6'b0) && (inst[5:1] == 5'b01101);
  assign is_signed_div = ~inst[0];

  // ID/EX register: bubble when EX stalls but MEM runs, load when EX runs, else hold
  always_comb begin
    id_ex_d = id_ex_q;
    if (stall[3] && !stall[4]) id_ex_d = '0;
    else if (!stall[3])        id_ex_d = id_to_ex_bus;
  end

  // Operand selection and ALU
  logic [31:0] src1, src2, result;
  logic signed [31:0] src1_s, src2_s;
  always_comb begin
    src1 = 32'b0;
    if (sel_src1[0])      src1 = rdata1;
    else if (sel_src1[1]) src1 = pc;
    else if (sel_src1[2]) src1 = {27'b0, inst[10:6]};
    src2 = 32'b0;
    if (sel_src2[0])      src2 = rdata2;
    else if (sel_src2[1]) src2 = {{16{inst[15]}}, inst[15:0]};
    else if (sel_src2[2]) src2 = 32'd8;
    else if (sel_src2[3]) src2 = {16'b0, inst[15:0]};
    src1_s = src1;
    src2_s = src2;
    result = 32'b0;
    if (alu_op[11]) result = result | (src1 + src2);
    if (alu_op[10]) result = result | (src1 - src2);
    if (alu_op[9])  result = result | {31'b0, src1_s < src2_s};
    if (alu_op[8])  result = result | {31'b0, src1 < src2};
    if (alu_op[7])  result = result | (src1 & src2);
    if (alu_op[6])  result = result | ~(src1 | src2);
    if (alu_op[5])  result = result | (src1 | src2);
    if (alu_op[4])  result = result | (src1 ^ src2);
    if (alu_op[3])  result = result | (src2 << src1[4:0]);
    if (alu_op[2])  result = result | (src2 >> src1[4:0]);
    if (alu_op[1])  result = result | $unsigned(src2_s >>> src1[4:0]);
    if (alu_op[0])  result = result | {src2[15:0], 16'b0};
  end

  // Store byte-lane enables and lane-replicated store data
  logic        is_store;
  logic [3:0]  mem_wen;
  logic [31:0] mem_wdata;
  always_comb begin
    is_store  = ram_en && (ram_wen != 4'b0);
    mem_wen   = 4'b0;
    mem_wdata = 32'b0;
    if (is_store) begin
      case (inst[31:26])
        OP_SB: begin
          mem_wen   = 4'b0001 << result[1:0];
          mem_wdata = {4{rdata2[7:0]}};
        end
        OP_SH: begin
          mem_wen   = result[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{rdata2[15:0]}};
        end
        default: begin
          mem_wen   = 4'hF;
          mem_wdata = rdata2;
        end
      endcase
    end
  end

  // Divider sequencing: latch magnitudes, 32 restoring steps, one-cycle write-back
  logic [32:0] trial;
  logic        s1_neg, s2_neg, q_bit;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    s1_neg  = is_signed_div & rdata1[31];
    s2_neg  = is_signed_div & rdata2[31];
    trial   = {rem_q, dvd_q[31]};
    q_bit   = (trial >= {1'b0, dvs_q});
    case (state_q)
      ST_IDLE: begin
        if (is_div) begin
          state_d = ST_BUSY;
          cnt_d   = 6'd0;
          dvd_d   = s1_neg ? -rdata1 : rdata1;
          dvs_d   = s2_neg ? -rdata2 : rdata2;
          rem_d   = 32'b0;
          q_neg_d = s1_neg ^ s2_neg;
          r_neg_d = s1_neg;
          dz_d    = (rdata2 == 32'b0);
        end
      end
      ST_BUSY: begin
        rem_d = q_bit ? 32'(trial - {1'b0, dvs_q}) : trial[31:0];
        dvd_d = {dvd_q[30:0], q_bit};
        cnt_d = cnt_q + 6'd1;
        if (!is_div)              state_d = ST_IDLE;
        else if (cnt_q == 6'd31)  state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex_q <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      dvd_q   <= 32'b0;
      rem_q   <= 32'b0;
      dvs_q   <= 32'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      id_ex_q <= id_ex_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
    end
  end

  // Output forming; everything downstream sees a bubble while a divide is stalling
  logic done;
  always_comb begin
    done            = (state_q == ST_DONE);
    stallreq        = is_div && !done;
    hilo_we         = done;
    hi_wdata        = done ? (r_neg_q ? -rem_q : rem_q) : 32'b0;
    lo_wdata        = !done ? 32'b0 : dz_q ? 32'hFFFF_FFFF : (q_neg_q ? -dvd_q : dvd_q);
    ex_to_mem_bus   = stallreq ? '0 : EX_TO_MEM_WD'({pc, ram_en, ram_wen, sel_rf_res,
                                                     rf_we, rf_waddr, result});
    ex_to_id_bus    = stallreq ? 38'b0 : {rf_we, rf_waddr, result};
    data_sram_en    = stallreq ? 1'b0 : ram_en;
    data_sram_wen   = stallreq ? 4'b0 : mem_wen;
    data_sram_addr  = result;
    data_sram_wdata = mem_wdata;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline; it consumes the ID→EX bus that the decode stage produces.
- Holds the ID/EX pipeline register and resolves ALU operands from the one-hot selects, then computes the 12-op ALU result.
- Drives the data SRAM request and forms the EX→MEM bus.
- Runs a 32-iteration sequential divider for div/divu, stalling the front of the pipeline via stallreq until HI/LO are written.

Parameters:
- ID_TO_EX_WD, 159, width of incoming decode bus.
- EX_TO_MEM_WD, 76, width of outgoing bus.
- STALL_WD, 6, stall vector width. Bit order: [0]pc, [1]if, [2]id, [3]ex, [4]mem, [5]wb. Stop=1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- stall  in  STALL_WD  pipeline stall vector.
- id_to_ex_bus  in  159  {pc[158:127], inst[126:95], alu_op[94:83], sel_src1[82:80], sel_src2[79:76], ram_en[75], ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rdata1[63:32], rdata2[31:0]}.
- ex_to_mem_bus  out  76  {pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], result[31:0]}.
- ex_to_id_bus  out  38  {rf_we, rf_waddr, result}; forwarding path, same gating as ex_to_mem_bus.
- data_sram_en  out  1  data RAM enable.
- data_sram_wen  out  4  byte write enables.
- data_sram_addr  out  32  data RAM address.
- data_sram_wdata  out  32  store data.
- hilo_we  out  1  HI/LO write strobe.
- hi_wdata  out  32  remainder.
- lo_wdata  out  32  quotient.
- stallreq  out  1  EX stall request.

Behaviour:

Pipeline register:
- On reset, clear to 0.
- If stall[3]=1 and stall[4]=0, load 0 (bubble).
- Else if stall[3]=0, load id_to_ex_bus.
- Otherwise hold.

Operand selection:
- src1 = rdata1 if sel_src1[0]; pc if [1]; {27'b0, inst[10:6]} if [2]; 0 if none.
- src2 = rdata2 if sel_src2[0]; sign-extended inst[15:0] if [1]; 32'd8 if [2]; zero-extended inst[15:0] if [3].

ALU (alu_op one-hot):
- Bit order [11:0]: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
- Shift ops shift src2 by src1[4:0].
- lui = {src2[15:0], 16'b0}.
- slt/sltu return 0 or 1.
- All arithmetic is 32-bit modulo; no overflow trap.

Memory request:
- data_sram_en = ram_en.
- data_sram_addr = result.
- sw: wen=4'hF, wdata=rdata2.
- sb: wen = 1 << result[1:0], wdata = byte replicated ×4.
- sh: wen = 4'b0011 or 4'b1100 by result[1], wdata = half replicated ×2.
- Loads: wen = 0.

Divider detection and FSM:
- An instruction is a divide when inst[31:26]=0 and inst[5:0] = 011010 (div) or 011011 (divu).
- States: IDLE, BUSY, DONE.
- IDLE → BUSY: when the register holds a divide. Latch |rs|, |rt| (raw values for divu), record sign flags, clear the 6-bit count.
- BUSY: one restoring shift-subtract step per cycle; count increments. After 32 steps (count==31 at the edge) → DONE.
- DONE: apply sign fix. Quotient is negated if the operand signs differ; remainder takes the dividend's sign. Assert hilo_we for exactly 1 cycle, then → IDLE.
- Divide by zero: hi=rs, lo=32'hFFFF_FFFF, no sign fix, same latency.
- stallreq = divide present and state≠DONE. Timing with the divide entering EX at cycle 0: stallreq=1 for cycles 0..32, hilo_we=1 in cycle 33.

Bubble gating:
- While stallreq=1, ex_to_mem_bus, ex_to_id_bus and data_sram_en/wen are forced to 0.
- Non-divide instructions never assert stallreq.

Reset and outputs:
- Reset mid-divide (async) → IDLE, count 0, all datapath registers 0, hilo_we=0, stallreq=0.
- All outputs are 0 out of reset.

Test Plan:
- addu, rdata1=0x7FFFFFFF, rdata2=1 → result 0x80000000, rf_we=1, rf_waddr passed through, no stallreq.
- sb at rdata1=0x1001 with offset 2, rdata2=0x000000AB → addr 0x1003, wen 4'b1000, wdata 0xABABABAB.
- divu 100/7 → stallreq high 33 cycles; then hilo_we pulse with lo=14, hi=2; ex_to_mem_bus all-zero while stalled.
- div −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 7/0 → lo=0xFFFFFFFF, hi=7.
- Assert rst low at BUSY count 10 → stallreq and hilo_we drop immediately; a new divu 9/3 then completes with lo=3, hi=0.
- stall[3]=1, stall[4]=0 → register becomes a bubble (rf_we=0); stall[3]=1, stall[4]=1 → register value held.
